// File: rtl/boot_loader_pkg.sv
// Shared types and widths for the boot loader: FSM state encoding and datapath sizes.
package boot_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int CNT_W          = 16;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef enum logic [2:0] {
    ST_LEN0  = 3'd0,
    ST_LEN1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  // States in which the host link may hand us a byte.
  function automatic logic takes_bytes(input state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

  // States counted as "load in progress".
  function automatic logic is_loading(input state_t s);
    return takes_bytes(s) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
module boot_loader_byte_packer
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [BYTE_W-1:0] data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]               idx;
  logic [WORD_W-BYTE_W-1:0] low;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= 2'd0;
      low <= '0;
    end else if (clear) begin
      idx <= 2'd0;
      low <= '0;
    end else if (load) begin
      case (idx)
        2'd0:    low[BYTE_W-1:0]          <= data;
        2'd1:    low[2*BYTE_W-1:BYTE_W]   <= data;
        2'd2:    low[3*BYTE_W-1:2*BYTE_W] <= data;
        default: ;
      endcase
      idx <= idx + 2'd1;
    end
  end

  // The top byte is forwarded straight from the input so the word is
  // complete on the same edge that consumes the fourth byte.
  assign word_valid = load && (idx == 2'd3);
  assign word       = {data, low};

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed, XOR-checksummed byte image into memory and
// releases the core from reset once the image verifies.
//
// state | meaning
// LEN0  | waiting for word count low byte
// LEN1  | waiting for word count high byte; range-check N
// DATA  | collecting payload bytes into the current word
// WRITE | one-cycle memory write strobe, advance address/count
// CHK   | waiting for the checksum byte
// DONE  | image verified, core released (terminal)
// ERROR | oversize header or bad checksum, core held (terminal)
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_WORDS);

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic [BYTE_W-1:0] len_lo;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  len_hdr;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  word_cnt_inc;
  logic [BYTE_W-1:0] chk;
  logic              packer_clear;
  logic              packer_load;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  // busy is low only in the first cycle after reset and in the terminal
  // states, so gating with it gives the one-cycle hold-off after release.
  always_comb begin
    in_ready = 1'b0;
    if (takes_bytes(state)) in_ready = busy;
  end

  assign accept       = in_valid && in_ready;
  assign len_hdr      = {in_data, len_lo};
  assign word_cnt_inc = word_cnt + 1'b1;
  assign packer_clear = (state == ST_LEN0) || (state == ST_LEN1);
  assign packer_load  = accept && (state == ST_DATA);

  boot_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (packer_clear),
    .load       (packer_load),
    .data       (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_LEN0: if (accept) next_state = ST_LEN1;
      ST_LEN1: begin
        if (accept) begin
          if (len_hdr == '0)          next_state = ST_CHK;
          else if (len_hdr > MAX_LEN) next_state = ST_ERROR;
          else                        next_state = ST_DATA;
        end
      end
      ST_DATA: if (word_valid) next_state = ST_WRITE;
      ST_WRITE: next_state = (word_cnt_inc == len) ? ST_CHK : ST_DATA;
      ST_CHK: begin
        if (accept) next_state = (in_data == chk) ? ST_DONE : ST_ERROR;
      end
      ST_DONE:  next_state = ST_DONE;
      ST_ERROR: next_state = ST_ERROR;
      default:  next_state = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_LEN0;
      len_lo     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      chk        <= '0;
      mem_write  <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      core_reset <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= is_loading(next_state);
      done       <= (next_state == ST_DONE);
      error      <= (next_state == ST_ERROR);
      mem_write  <= (next_state == ST_WRITE);
      core_reset <= (state == ST_DONE);
      if (word_valid) mem_wdata <= word;
      if (accept && (state == ST_LEN0)) len_lo <= in_data;
      if (accept && (state == ST_LEN1)) len <= len_hdr;
      if (accept && (state == ST_DATA)) chk <= chk ^ in_data;
      if (state == ST_WRITE) begin
        mem_addr <= mem_addr + 32'd4;
        word_cnt <= word_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: good/bad checksum, oversize and empty
// headers, stalled input, and reset in the middle of a load.
module tb_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] exp_words[$];
  logic [7:0]  good_stream[$];
  logic [7:0]  bad_stream[$];

  boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hA5;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gaps);
    foreach (s[i]) send_byte(s[i], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    check({tag, "_count"}, wr_addr.size(), n_exp);
    for (int i = 0; i < n_exp && i < wr_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr[i], BASE + 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_words[i]);
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    exp_words   = '{32'h1234_5678, 32'hDEAD_BEEF};
    // Payload XOR: 78^56^34^12^EF^BE^AD^DE = 0x2A.
    good_stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    bad_stream  = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};

    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_core_reset", core_reset, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clk);
    reset = 1'b1;
    check("first_cycle_in_ready", in_ready, 0);
    @(negedge clk);
    check("len0_in_ready", in_ready, 1);
    check("len0_busy", busy, 1);

    // Good stream, no gaps, with a latency check on the first word.
    for (int i = 0; i < good_stream.size(); i++) begin
      send_byte(good_stream[i], 0);
      if (i == 5) begin
        check("t1_wr_pulse", mem_write, 1);
        check("t1_wr_addr", mem_addr, BASE);
        check("t1_wr_data", mem_wdata, 32'h1234_5678);
        check("t1_wr_ready", in_ready, 0);
      end
    end
    check("t1_done", done, 1);
    check("t1_error", error, 0);
    check("t1_busy", busy, 0);
    check("t1_core_reset_entry", core_reset, 0);
    check("t1_final_addr", mem_addr, BASE + 32'd8);
    @(negedge clk);
    check("t1_core_reset_after", core_reset, 1);
    check("t1_in_ready", in_ready, 0);
    check_writes("t1", 2);

    // Bad checksum.
    do_reset();
    send_stream(bad_stream, 1'b0);
    check("t2_error", error, 1);
    check("t2_done", done, 0);
    in_valid = 1'b1;
    in_data  = 8'h2A;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("t2_core_reset", core_reset, 0);
    check("t2_in_ready", in_ready, 0);
    check("t2_error_hold", error, 1);
    check_writes("t2", 2);

    // Oversize header N=257.
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("t3_error", error, 1);
    check("t3_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("t3_done", done, 0);
    check_writes("t3", 0);

    // Empty image.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t4_chk_ready", in_ready, 1);
    send_byte(8'h00, 0);
    check("t4_done", done, 1);
    check("t4_addr", mem_addr, BASE);
    check_writes("t4", 0);

    // Good stream with random input stalls.
    do_reset();
    send_stream(good_stream, 1'b1);
    check("t5_done", done, 1);
    check_writes("t5", 2);

    // Reset in the middle of DATA, after one word is already written.
    do_reset();
    send_stream(good_stream[0:6], 1'b0);
    check("t6_mid_addr", mem_addr, BASE + 32'd4);
    check("t6_mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_addr", mem_addr, BASE);
    check("t6_rst_wdata", mem_wdata, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_write", mem_write, 0);
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    reset = 1'b1;
    @(negedge clk);
    send_stream(good_stream, 1'b0);
    check("t6_done", done, 1);
    check_writes("t6", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
